// File: rtl/pc_fetch_stage.sv
// Program-counter and instruction-fetch stage: keeps one imem request in flight
// and hands each fetched instruction, its PC and PC+4 to decode over valid/ready.
module pc_fetch_stage #(
  parameter int         N        = 31,
  parameter logic [N:0] RESET_PC = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [N:0]  redirect_pc,
  output logic [N:0]  inc_a,
  output logic [N:0]  inc_b,
  input  logic [N:0]  inc_sum,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [N:0]  imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [N:0]  if_pc,
  output logic [N:0]  if_pc_plus4,
  output logic [31:0] if_instr
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic [N:0] PC_STEP = (N+1)'(4);

  state_t     state_q, state_d;
  logic [N:0] pc_q;
  logic [N:0] req_pc_q;
  logic [N:0] req_pc_plus4_q;
  logic       drop_q;
  logic [N:0] redirect_target;
  logic       req_fire;
  logic       resp_accept;

  // Instruction fetches are word aligned, so the low target bits are discarded.
  assign redirect_target = {redirect_pc[N:2], 2'b00};

  assign inc_a = pc_q;
  assign inc_b = PC_STEP;

  assign req_fire    = imem_req_valid && imem_req_ready;
  assign resp_accept = (state_q == S_WAIT) && imem_resp_valid && !redirect_valid && !drop_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_REQ;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ:   if (req_fire) state_d = S_WAIT;
      S_WAIT:  if (imem_resp_valid) state_d = resp_accept ? S_OUT : S_REQ;
      S_OUT:   if (redirect_valid || if_ready) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    imem_req_valid = 1'b0;
    if (state_q == S_REQ) imem_req_valid = !redirect_valid;
  end

  assign imem_addr = pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      if_valid    <= 1'b0;
      if_pc       <= '0;
      if_pc_plus4 <= '0;
      if_instr    <= '0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (redirect_valid)      pc_q <= redirect_target;
          else if (imem_req_ready) pc_q <= inc_sum;
        end
        S_WAIT: begin
          if (redirect_valid) pc_q <= redirect_target;
          // A redirect with no response leaves a stale response still owed.
          if (imem_resp_valid)     drop_q <= 1'b0;
          else if (redirect_valid) drop_q <= 1'b1;
          if (resp_accept) begin
            if_instr    <= imem_resp_data;
            if_pc       <= req_pc_q;
            if_pc_plus4 <= req_pc_plus4_q;
            if_valid    <= 1'b1;
          end
        end
        S_OUT: begin
          if (redirect_valid) begin
            if_valid <= 1'b0;
            pc_q     <= redirect_target;
          end else if (if_ready) begin
            if_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: these hold pure data that is always written before it is read, so
  // they carry no reset.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      req_pc_q       <= pc_q;
      req_pc_plus4_q <= inc_sum;
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed self-checking bench for pc_fetch_stage; the bench also plays the
// external incrementer and the instruction memory.
module tb_pc_fetch_stage;

  localparam int N = 31;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [N:0]  redirect_pc;
  logic [N:0]  inc_a, inc_b, inc_sum;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [N:0]  imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [N:0]  if_pc, if_pc_plus4;
  logic [31:0] if_instr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign inc_sum = inc_a + inc_b;

  pc_fetch_stage #(.N(N), .RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inc_a(inc_a), .inc_b(inc_b), .inc_sum(inc_sum),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_instr(if_instr)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    if_ready = 1'b0;
    tick(); tick();
    settle();
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_pc_plus4", if_pc_plus4, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_addr", imem_addr, 32'h100);
    check("inc_b_const", inc_b, 32'h4);

    // Sequential fetch from RESET_PC.
    rst = 1'b0; imem_req_ready = 1'b1; if_ready = 1'b1;
    settle();
    check("seq0_req_valid", 32'(imem_req_valid), 32'd1);
    check("seq0_addr", imem_addr, 32'h100);
    tick();
    imem_resp_valid = 1'b1; imem_resp_data = 32'hAAAA_0001;
    settle();
    check("seq0_wait_no_req", 32'(imem_req_valid), 32'd0);
    check("seq0_inc_a", inc_a, 32'h104);
    tick();
    imem_resp_valid = 1'b0;
    settle();
    check("seq0_if_valid", 32'(if_valid), 32'd1);
    check("seq0_if_pc", if_pc, 32'h100);
    check("seq0_if_pc_plus4", if_pc_plus4, 32'h104);
    check("seq0_if_instr", if_instr, 32'hAAAA_0001);
    tick();
    settle();
    check("seq1_if_valid_low", 32'(if_valid), 32'd0);
    check("seq1_req_valid", 32'(imem_req_valid), 32'd1);
    check("seq1_addr", imem_addr, 32'h104);
    tick();
    imem_resp_valid = 1'b1; imem_resp_data = 32'hAAAA_0002;
    tick();
    imem_resp_valid = 1'b0;

    // Decode stalls for 5 cycles: the presented instruction is held.
    if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("stall_if_valid", 32'(if_valid), 32'd1);
      check("stall_if_pc", if_pc, 32'h104);
      check("stall_if_pc_plus4", if_pc_plus4, 32'h108);
      check("stall_if_instr", if_instr, 32'hAAAA_0002);
      check("stall_no_req", 32'(imem_req_valid), 32'd0);
      tick();
    end
    if_ready = 1'b1;
    tick();
    settle();
    check("after_stall_req", 32'(imem_req_valid), 32'd1);
    check("after_stall_addr", imem_addr, 32'h108);
    tick();

    // Redirect while waiting; the late response must be dropped.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2002;
    tick();
    redirect_valid = 1'b0;
    tick();
    settle();
    check("drop_wait_no_req", 32'(imem_req_valid), 32'd0);
    tick();
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid = 1'b0;
    settle();
    check("drop_if_valid", 32'(if_valid), 32'd0);
    check("drop_req_valid", 32'(imem_req_valid), 32'd1);
    check("drop_addr_aligned", imem_addr, 32'h2000);
    tick();
    imem_resp_valid = 1'b1; imem_resp_data = 32'hBBBB_0003;
    tick();
    imem_resp_valid = 1'b0;
    settle();
    check("redir_if_valid", 32'(if_valid), 32'd1);
    check("redir_if_pc", if_pc, 32'h2000);
    check("redir_if_pc_plus4", if_pc_plus4, 32'h2004);
    check("redir_if_instr", if_instr, 32'hBBBB_0003);
    tick();

    // Redirect in S_REQ with memory ready: no request that cycle.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    settle();
    check("req_redir_no_req", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    settle();
    check("req_redir_req", 32'(imem_req_valid), 32'd1);
    check("req_redir_addr", imem_addr, 32'h40);
    tick();
    imem_resp_valid = 1'b1; imem_resp_data = 32'hCCCC_0004;
    tick();
    imem_resp_valid = 1'b0;
    settle();
    check("req_redir_if_pc", if_pc, 32'h40);
    check("req_redir_if_instr", if_instr, 32'hCCCC_0004);

    // Redirect in S_OUT squashes the instruction even with if_ready=1.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    settle();
    check("squash_if_valid", 32'(if_valid), 32'd0);
    check("squash_req", 32'(imem_req_valid), 32'd1);
    check("squash_addr", imem_addr, 32'h300);
    tick();

    // Reset in S_WAIT; the stale response then lands in S_REQ.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'hEEEE_EEEE;
    settle();
    check("rst_mid_if_valid", 32'(if_valid), 32'd0);
    check("rst_mid_req", 32'(imem_req_valid), 32'd1);
    check("rst_mid_addr", imem_addr, 32'h100);
    tick();
    imem_resp_valid = 1'b0;
    settle();
    check("stale_ignored_valid", 32'(if_valid), 32'd0);
    check("stale_ignored_instr", if_instr, 32'h0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'hF0F0_F0F0;
    tick();
    imem_resp_valid = 1'b0;
    settle();
    check("rst_mid_if_pc", if_pc, 32'h100);
    check("rst_mid_if_instr", if_instr, 32'hF0F0_F0F0);
    tick();

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    settle();
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    imem_resp_valid = 1'b1; imem_resp_data = 32'h1234_5678;
    tick();
    imem_resp_valid = 1'b0;
    settle();
    check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    check("wrap_if_pc_plus4", if_pc_plus4, 32'h0);
    tick();
    settle();
    check("wrap_next_addr", imem_addr, 32'h0);
    tick();

    // Redirect together with a response in S_WAIT: response discarded.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0500;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h5555_5555;
    tick();
    redirect_valid = 1'b0; imem_resp_valid = 1'b0;
    settle();
    check("both_if_valid", 32'(if_valid), 32'd0);
    check("both_req", 32'(imem_req_valid), 32'd1);
    check("both_addr", imem_addr, 32'h500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
